// File: rtl/music_ctrl.sv
// Button front end + play/pause/stop FSM for the buzzer player; optional replay via `MUSIC_LOOP_EN.
// Latency: raw key edge to press pulse about DEBOUNCE_CYC+2 clk; FSM outputs registered from next-state.
// No backpressure: play_done is consumed every cycle, and ignored while IDLE.
`timescale 1ns/1ps
module music_ctrl #(
  parameter int          DEBOUNCE_CYC = 1_000_000,
  parameter logic [7:0]  LOOP_CNT     = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_play_n,
  input  logic       key_pause_n,
  input  logic       play_done,
  output logic       play_en,
  output logic       start_stop,
  output logic       busy,
  output logic [1:0] ctrl_state,
  output logic [7:0] done_cnt
);

  localparam int             CW      = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b11,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // Bit 0 = play key, bit 1 = pause key; all levels idle high (released).
  logic [1:0]    key_s1, key_s2, key_db, key_db_d;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic          play_pr, pause_pr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1    <= 2'b11;
      key_s2    <= 2'b11;
      key_db    <= 2'b11;
      key_db_d  <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      key_s1   <= {key_pause_n, key_play_n};
      key_s2   <= key_s1;
      key_db_d <= key_db;
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_cnt[i] <= '0;
          key_db[i] <= key_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press    = key_db_d & ~key_db;
  assign play_pr  = press[0];
  assign pause_pr = press[1];

  state_t state, state_nx;
  logic   loop_again;

`ifdef MUSIC_LOOP_EN
  logic [7:0] loop_rem;
  logic       loop_load, loop_dec;

  assign loop_again = (loop_rem != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         loop_rem <= 8'd0;
    else if (loop_load) loop_rem <= LOOP_CNT;
    else if (loop_dec)  loop_rem <= loop_rem - 8'd1;
  end
`else
  logic unused_loop_cnt;
  assign unused_loop_cnt = ^LOOP_CNT;
  assign loop_again      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
`ifdef MUSIC_LOOP_EN
    loop_load = 1'b0;
    loop_dec  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (play_pr) begin
          state_nx = S_START;
`ifdef MUSIC_LOOP_EN
          loop_load = 1'b1;
`endif
        end
      end
      S_START: state_nx = S_RUN;
      S_RUN, S_PAUSE: begin
        // Tune completion outranks any key press landing in the same cycle.
        if (play_done) begin
          state_nx = loop_again ? S_START : S_IDLE;
`ifdef MUSIC_LOOP_EN
          loop_dec = loop_again;
`endif
        end else if (state == S_RUN) begin
          if (pause_pr) state_nx = S_PAUSE;
        end else if (play_pr || pause_pr) begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_en    <= 1'b0;
      start_stop <= 1'b0;
      done_cnt   <= 8'd0;
    end else begin
      play_en    <= (state_nx == S_START);
      start_stop <= (state_nx == S_START) || (state_nx == S_RUN);
      if (play_done && (state != S_IDLE) && (done_cnt != 8'hFF))
        done_cnt <= done_cnt + 8'd1;
    end
  end

  assign busy       = (state != S_IDLE);
  assign ctrl_state = state;

endmodule
